// File: rtl/board_io.sv
// Board I/O front-end: synchronised, debounced switches/buttons with sticky
// press flags, plus a multiplexed active-low seven-segment display scanner.
module board_io #(
   parameter int N_SW            = 16,
   parameter int N_BTN           = 4,
   parameter int N_DIGITS        = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SCAN_CYCLES     = 100_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_SW-1:0]       sw_raw,
   input  logic [N_BTN-1:0]      btn_raw,
   output logic [N_SW-1:0]       sw_q,
   output logic [N_BTN-1:0]      btn_q,
   output logic [N_BTN-1:0]      btn_evt,
   input  logic [N_BTN-1:0]      evt_clr,
   input  logic [4*N_DIGITS-1:0] disp_val,
   input  logic [N_DIGITS-1:0]   disp_dp,
   input  logic [N_DIGITS-1:0]   disp_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an
);
   localparam int NIN = N_SW + N_BTN;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW  = $clog2(SCAN_CYCLES + 1);
   localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   function automatic logic [6:0] hex_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [NIN-1:0]      sync1_q, sync2_q, deb_q, deb_d;
   logic [CW-1:0]       cnt_q [NIN];
   logic [CW-1:0]       cnt_d [NIN];
   logic [N_BTN-1:0]    btn_prev_q, evt_q, evt_d;
   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [N_DIGITS-1:0] sel_s;
   logic [3:0]          nib_s;
   logic                en_s, dpl_s;

   // Per-bit debounce: accept a new level only after an unbroken mismatch run.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NIN; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      evt_d = (evt_q & ~evt_clr) | (deb_q[NIN-1:N_SW] & ~btn_prev_q);
   end

   // Scan position and the digit image registered from the current index.
   always_comb begin
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
         pre_d = pre_q + PW'(1);
         idx_d = idx_q;
      end
      sel_s = '0;
      nib_s = 4'h0;
      for (int d = 0; d < N_DIGITS; d++) begin
         sel_s[d] = (idx_q == IW'(d));
         nib_s    = nib_s | (disp_val[4*d +: 4] & {4{sel_s[d]}});
      end
      en_s  = |(disp_en & sel_s);
      dpl_s = |(disp_dp & sel_s);
      if (en_s) begin
         seg_d = hex_seg(nib_s);
         dp_d  = ~dpl_s;
         an_d  = ~sel_s;
      end else begin
         seg_d = 7'b1111111;
         dp_d  = 1'b1;
         an_d  = '1;
      end
   end

   // State registers; reset returns every output to its idle/blank value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
         btn_prev_q <= '0;
         evt_q      <= '0;
         pre_q      <= '0;
         idx_q      <= '0;
         seg_q      <= 7'b1111111;
         dp_q       <= 1'b1;
         an_q       <= '1;
      end else begin
         sync1_q    <= {btn_raw, sw_raw};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
         btn_prev_q <= deb_q[NIN-1:N_SW];
         evt_q      <= evt_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign sw_q    = deb_q[N_SW-1:0];
   assign btn_q   = deb_q[NIN-1:N_SW];
   assign btn_evt = evt_q;
   assign seg     = seg_q;
   assign dp      = dp_q;
   assign an      = an_q;

endmodule

// File: tb/tb_board_io.sv
// Self-checking bench for board_io: a sliding-window/frame-count reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_board_io;
   localparam int N_SW = 16, N_BTN = 4, N_DIGITS = 4, DEB = 8, SCAN = 4;
   localparam int NIN = N_SW + N_BTN;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [N_SW-1:0]       sw_raw;
   logic [N_BTN-1:0]      btn_raw;
   logic [N_SW-1:0]       sw_q;
   logic [N_BTN-1:0]      btn_q;
   logic [N_BTN-1:0]      btn_evt;
   logic [N_BTN-1:0]      evt_clr;
   logic [4*N_DIGITS-1:0] disp_val;
   logic [N_DIGITS-1:0]   disp_dp;
   logic [N_DIGITS-1:0]   disp_en;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;

   int tests = 0;
   int fails = 0;

   board_io #(.N_SW(N_SW), .N_BTN(N_BTN), .N_DIGITS(N_DIGITS),
              .DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .btn_raw(btn_raw),
      .sw_q(sw_q), .btn_q(btn_q), .btn_evt(btn_evt), .evt_clr(evt_clr),
      .disp_val(disp_val), .disp_dp(disp_dp), .disp_en(disp_en),
      .seg(seg), .dp(dp), .an(an));

   always #5 clk = ~clk;

   logic [6:0] seg_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_rng(input string nm, input int val, input int lo, input int hi);
      tests++;
      if (val < lo || val > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d at %0t", nm, val, lo, hi, $time);
      end
   endtask

   // Reference model: raw samples per edge; a bit flips once the last DEB
   // synchronised samples (2 edges old) all disagree with its current level.
   logic [NIN-1:0]      hist [DEB+2];
   logic [NIN-1:0]      mq, mq_prev;
   logic [N_BTN-1:0]    mevt;
   int                  ecnt;
   logic [6:0]          mseg;
   logic                mdp;
   logic [N_DIGITS-1:0] man;

   task automatic model_reset();
      for (int j = 0; j < DEB + 2; j++) hist[j] = '0;
      mq = '0; mq_prev = '0; mevt = '0; ecnt = 0;
      mseg = 7'b1111111; mdp = 1'b1; man = '1;
   endtask

   task automatic model_step();
      logic [NIN-1:0] nq;
      logic           all_diff;
      int             d;
      for (int j = DEB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {btn_raw, sw_raw};
      nq = mq;
      for (int b = 0; b < NIN; b++) begin
         all_diff = 1'b1;
         for (int j = 2; j <= DEB + 1; j++)
            if (hist[j][b] == mq[b]) all_diff = 1'b0;
         if (all_diff) nq[b] = ~mq[b];
      end
      mevt = (mevt & ~evt_clr) | (mq[NIN-1:N_SW] & ~mq_prev[NIN-1:N_SW]);
      mq_prev = mq;
      mq = nq;
      ecnt++;
      d = ((ecnt - 1) / SCAN) % N_DIGITS;
      if (disp_en[d]) begin
         man = '1;
         man[d] = 1'b0;
         mseg = seg_tbl[disp_val[4*d +: 4]];
         mdp = ~disp_dp[d];
      end else begin
         man = '1; mseg = 7'b1111111; mdp = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         check("m_sw_q",    sw_q,    mq[N_SW-1:0]);
         check("m_btn_q",   btn_q,   mq[NIN-1:N_SW]);
         check("m_btn_evt", btn_evt, mevt);
         check("m_seg",     seg,     mseg);
         check("m_dp",      dp,      mdp);
         check("m_an",      an,      man);
         if (rst_n) model_step();
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] exp_seg [4] = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
   logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      int n, rises;
      logic prev_b;
      logic [3:0] prev_an;
      rst_n = 1'b0; sw_raw = '0; btn_raw = '0; evt_clr = '0;
      disp_val = '0; disp_dp = '0; disp_en = '0;
      step(3);
      check("rst_sw_q", sw_q, 16'h0000);
      check("rst_evt", btn_evt, 4'h0);
      check("rst_seg", seg, 7'b1111111);
      check("rst_dp", dp, 1'b1);
      check("rst_an", an, 4'hF);
      rst_n = 1'b1;
      disp_val = 16'h1A2F; disp_en = 4'b1111; disp_dp = 4'b0100;
      step(5);

      // clean press
      btn_raw[0] = 1'b1;
      n = 0;
      while (btn_q[0] == 1'b0 && n < 20) begin step(1); n++; end
      check_rng("press_latency", n, 9, 11);
      check("press_evt_early", btn_evt[0], 1'b0);
      check("press_sw_unchanged", sw_q, 16'h0000);
      step(1);
      check("press_evt", btn_evt[0], 1'b1);

      // bounce on button 1
      rises = 0; n = 0; prev_b = btn_q[1];
      for (int k = 0; k < 10; k++) begin
         btn_raw[1] = ~btn_raw[1];
         for (int c = 0; c < 3; c++) begin
            step(1);
            if (btn_q[1] != 1'b0) n++;
         end
      end
      check("bounce_quiet", n, 0);
      btn_raw[1] = 1'b1;
      n = 0;
      while (btn_q[1] == 1'b0 && n < 20) begin step(1); n++; end
      check_rng("bounce_latency", n, 9, 11);
      for (int c = 0; c < 15; c++) begin
         if (btn_q[1] && !prev_b) rises++;
         prev_b = btn_q[1];
         step(1);
      end
      check("bounce_one_rise", rises, 1);
      check("bounce_evt", btn_evt[1], 1'b1);
      evt_clr[1] = 1'b1; step(1); evt_clr[1] = 1'b0;
      step(15);
      check("bounce_no_second_evt", btn_evt[1], 1'b0);

      // release sets nothing; clear/set race; lone clear
      btn_raw[0] = 1'b0;
      n = 0;
      while (btn_q[0] == 1'b1 && n < 20) begin step(1); n++; end
      check_rng("release_latency", n, 9, 11);
      step(2);
      check("release_evt_kept", btn_evt[0], 1'b1);
      btn_raw[0] = 1'b1;
      n = 0;
      while (btn_q[0] == 1'b0 && n < 20) begin step(1); n++; end
      evt_clr[0] = 1'b1; step(1); evt_clr[0] = 1'b0;
      check("race_set_wins", btn_evt[0], 1'b1);
      step(2);
      evt_clr[0] = 1'b1; step(1); evt_clr[0] = 1'b0;
      check("lone_clear", btn_evt[0], 1'b0);

      // scan frame
      n = 0; prev_an = an;
      @(negedge clk);
      while (!(an == 4'b1110 && prev_an == 4'b0111) && n < 40) begin
         prev_an = an; @(negedge clk); n++;
      end
      check_rng("scan_sync", n, 0, 39);
      for (int i = 0; i < 16; i++) begin
         check("scan_an", an, exp_an[i/4]);
         check("scan_seg", seg, exp_seg[i/4]);
         check("scan_dp", dp, exp_dp[i/4]);
         @(negedge clk);
      end
      check("scan_wrap", an, 4'b1110);

      // blanking of digit 2
      step(1);
      disp_en = 4'b1011;
      n = 0; prev_an = an;
      @(negedge clk);
      while (!(an == 4'b1111 && prev_an == 4'b1101) && n < 40) begin
         prev_an = an; @(negedge clk); n++;
      end
      check_rng("blank_sync", n, 0, 39);
      for (int i = 0; i < 4; i++) begin
         check("blank_an", an, 4'b1111);
         check("blank_seg", seg, 7'b1111111);
         check("blank_dp", dp, 1'b1);
         @(negedge clk);
      end
      check("blank_next", an, 4'b0111);
      step(1);
      disp_en = 4'b1111;

      // asynchronous reset mid-operation
      sw_raw = 16'hFFFF;
      step(15);
      check("sw_all_on", sw_q, 16'hFFFF);
      n = 0;
      @(negedge clk);
      while (an != 4'b0111 && n < 20) begin @(negedge clk); n++; end
      check_rng("digit3_sync", n, 0, 19);
      #1 rst_n = 1'b0;
      #1;
      check("arst_sw_q", sw_q, 16'h0000);
      check("arst_btn_q", btn_q, 4'h0);
      check("arst_evt", btn_evt, 4'h0);
      check("arst_seg", seg, 7'b1111111);
      check("arst_dp", dp, 1'b1);
      check("arst_an", an, 4'hF);
      step(2);
      rst_n = 1'b1;
      n = 0;
      while (sw_q != 16'hFFFF && n < 20) begin step(1); n++; end
      check_rng("rearm_latency", n, 9, 11);
      step(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule

// File: doc/board_io.md
# board_io

Parametrised board I/O front-end for the FPGA board top level. It synchronises and debounces raw switches and buttons, and latches sticky button-press events for software. It also scans a multiplexed N-digit seven-segment display from a hex value. Its outputs feed the GPIO input word, and its display inputs are driven from the GPIO output word.

## Interface
Parameters:
- N_SW, 16, number of slide switches
- N_BTN, 4, number of push buttons
- N_DIGITS, 4, number of seven-segment digits (1..8)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new input level (>= 2)
- SCAN_CYCLES, 100_000, clock cycles each digit stays lit (>= 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: asynchronous assertion, active-low
- sw_raw  in  N_SW  raw switch levels (asynchronous)
- btn_raw  in  N_BTN  raw button levels, 1 = pressed (asynchronous)
- sw_q  out  N_SW  debounced switch levels
- btn_q  out  N_BTN  debounced button levels
- btn_evt  out  N_BTN  sticky press flags
- evt_clr  in  N_BTN  write-1-to-clear strobes for btn_evt
- disp_val  in  4*N_DIGITS  hex nibbles; digit i = disp_val[4i+3:4i]
- disp_dp  in  N_DIGITS  decimal point per digit, 1 = lit
- disp_en  in  N_DIGITS  digit enable, 0 = blank
- seg  out  7  segments a..g on seg[0]..seg[6], active-low
- dp  out  1  decimal point, active-low
- an  out  N_DIGITS  digit anodes, active-low one-hot

## Operation
Synchronisation:
- Every bit of sw_raw and btn_raw passes through a 2-FF synchroniser.

Debounce (one independent counter per input bit, width clog2(DEBOUNCE_CYCLES+1)):
- While the synchronised value equals q, the counter is held at 0.
- While it differs, the counter increments each cycle.
- When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, q takes the synchronised value on that edge and the counter returns to 0.
- Any single-cycle return to agreement clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.

Events:
- btn_evt[i] sets on the cycle after btn_q[i] rises 0->1.
- btn_evt[i] clears when evt_clr[i]=1.
- Set and clear in the same cycle: set wins.
- A release (1->0) sets nothing.

Display scan:
- A prescaler counts 0..SCAN_CYCLES-1 and wraps.
- On the wrap the digit index advances 0,1,..,N_DIGITS-1,0.
- seg, dp and an are registered from the current index each cycle.
- an[idx]=0 only if disp_en[idx]=1; all other an bits are 1.
- seg = hex decode of the nibble. Active-low values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- dp = ~disp_dp[idx].
- A disabled digit drives seg=1111111 and dp=1.

Reset (rst_n=0, asynchronous), all outputs and internal state:
- sw_q=0, btn_q=0, btn_evt=0
- seg=1111111, dp=1, an=all 1s
- synchronisers, counters, prescaler and index = 0
- Outputs hold these values while rst_n=0.
- Asserting reset mid-debounce or mid-scan discards progress. After release, any input held at 1 is re-accepted after the full latency.

## Timing
- Raw change to q change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles, with ±1 cycle of sampling uncertainty.
- btn_q rise to btn_evt visible: 1 cycle.
- evt_clr to btn_evt=0: 1 cycle.
- Digit dwell: exactly SCAN_CYCLES cycles. Full frame: N_DIGITS*SCAN_CYCLES cycles.
- disp_* changes reach seg/an after 1 cycle, with no tearing beyond that cycle.
- After reset release, digit 0 is driven from the first clock edge.
- Each period of DEBOUNCE_CYCLES and SCAN_CYCLES is exactly that many cycles; counters never overflow their width.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=8, SCAN_CYCLES=4, N_DIGITS=4.
- Clean press: btn_raw[0] 0->1 held -> btn_q[0]=1 after 10 cycles ±1; btn_evt[0]=1 one cycle later; sw_q unchanged.
- Bounce: btn_raw[1] toggles every 3 cycles for 30 cycles, then holds 1 -> btn_q[1] stays 0 during the bounce and rises 10±1 cycles after the last edge; exactly one event.
- Event clear race: evt_clr[0]=1 in the same cycle as a new rising btn_q[0] -> btn_evt[0] stays 1. A lone evt_clr[0] pulse -> btn_evt[0]=0 the next cycle.
- Scan: disp_val=16'h1A2F, disp_en=4'b1111, disp_dp=4'b0100 -> sequence an=1110/seg=0001110, an=1101/seg=0100100, an=1011/seg=0001000 with dp=0, an=0111/seg=1111001; each lasts 4 cycles, then wraps.
- Blanking: disp_en=4'b1011 -> during digit 2, an=1111, seg=1111111, dp=1.
- Reset mid-operation: assert rst_n=0 with sw_q=16'hFFFF and the scan at digit 3 -> all outputs at reset values immediately (asynchronous). After release with sw_raw held, sw_q=16'hFFFF returns after 10±1 cycles.
